// File: rtl/vector_assembler.sv
// Gathers four lane-tagged scalar writes into one vector; presented one cycle after the commit or completing write.
// Backpressure: while a vector is pending (o_valid=1) no scalar write is accepted (o_ready=0) until i_ready takes it.
module vector_assembler #(
  parameter int WIDTH       = 32,
  parameter bit AUTO_COMMIT = 1'b1
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_valid,
  output logic               o_ready,
  input  logic [1:0]         i_index,
  input  logic [WIDTH-1:0]   i_data,
  input  logic               i_commit,
  output logic               o_valid,
  input  logic               i_ready,
  output logic [4*WIDTH-1:0] o_vector,
  output logic [3:0]         o_mask
);

  typedef enum logic {
    COLLECT = 1'b0,
    OUTPUT  = 1'b1
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [4*WIDTH-1:0] staging;
  logic [3:0]         mask;
  logic [3:0]         mask_wr;
  logic               wr_acc;
  logic               emit;

  assign o_ready  = (state == COLLECT);
  assign o_valid  = (state == OUTPUT);
  assign o_vector = staging;
  assign o_mask   = mask;

  assign wr_acc  = i_valid && o_ready;
  assign emit    = o_valid && i_ready;
  assign mask_wr = mask | (4'b0001 << i_index);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state <= COLLECT;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      COLLECT: begin
        if (wr_acc && (i_commit || (AUTO_COMMIT && (mask_wr == 4'b1111)))) begin
          state_next = OUTPUT;
        end
      end
      OUTPUT: begin
        if (i_ready) begin
          state_next = COLLECT;
        end
      end
      default: state_next = COLLECT;
    endcase
  end

  // Lane 0 (x) lives in the MSBs; lanes are stored bit-exact.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      staging <= '0;
      mask    <= '0;
    end else if (emit) begin
      staging <= '0;
      mask    <= '0;
    end else if (wr_acc) begin
      for (int n = 0; n < 4; n++) begin
        if (i_index == n[1:0]) begin
          staging[(3-n)*WIDTH +: WIDTH] <= i_data;
        end
      end
      mask <= mask_wr;
    end
  end

endmodule

// File: doc/vector_assembler.md
Name: vector_assembler

Overview:
Builds a Vector4_t from a stream of FixedPoint_t scalar writes, each tagged with a 2-bit lane index. It is the inverse of the vector lane-select path: scalars enter over a valid/ready handshake, and a complete vector leaves over a second valid/ready handshake. It sits between scalar ALU results and vector consumers such as the register-file writeback and the vertex output stage.

Parameters:
- WIDTH, 32, bit width of one FixedPoint_t component; the output is 4*WIDTH bits.
- AUTO_COMMIT, 1, when 1 the block emits the vector automatically once all four lanes have been written; when 0 it emits only on i_commit.

Ports:
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  synchronous, active-high reset.
- i_valid  input  1  scalar write request.
- o_ready  output  1  block can accept a scalar write this cycle.
- i_index  input  2  target lane: 0=x, 1=y, 2=z, 3=w.
- i_data  input  WIDTH  scalar value (FixedPoint_t).
- i_commit  input  1  qualifies i_valid; this write is the last one for the vector.
- o_valid  output  1  assembled vector available.
- i_ready  input  1  downstream accepts the vector.
- o_vector  output  4*WIDTH  Vector4_t, packed as x in the MSBs and w in the LSBs.
- o_mask  output  4  lanes written in the presented vector; bit n corresponds to index n.

Behaviour:
- Reset is synchronous and active-high. One clock, i_clk; reset is i_reset.
- Reset values:
  - state=COLLECT.
  - staging register=0, mask=0.
  - o_valid=0, o_ready=1, o_vector=0, o_mask=0.
- State COLLECT:
  - o_ready=1, o_valid=0.
  - A write is accepted when i_valid && o_ready. It stores i_data into lane i_index and sets mask[i_index].
  - A second write to the same lane before emission overwrites the earlier value (last write wins); the mask is unchanged.
- Transition COLLECT->OUTPUT on an accepted write when either condition holds:
  - i_commit=1, or
  - AUTO_COMMIT=1 and the mask including this write equals 4'b1111.
- Latency: the commit or completing write is accepted at edge N; o_valid=1 from cycle N+1. The vector includes that write.
- State OUTPUT:
  - o_valid=1 and o_ready=0; i_valid is ignored and no write is accepted.
  - o_vector and o_mask hold steady while i_ready=0.
  - On o_valid && i_ready, return to COLLECT and clear the staging register and mask to 0. o_ready=1 in the following cycle. There is no same-cycle bypass, so throughput is at most one vector per 2 cycles for a single-write vector.
- Unwritten lanes are presented as 0 and their o_mask bit is 0.
- Commit with an empty mask cannot occur, because a commit always accompanies a write.
- i_commit without i_valid is ignored.
- o_vector and o_mask are driven from registers. In COLLECT they show the partial staging contents, which downstream must not use because o_valid=0.
- Reset asserted mid-assembly or during OUTPUT discards everything. The next cycle shows reset values with no spurious o_valid.
- No arithmetic is performed; data is stored bit-exact with no sign extension or saturation.

Test Plan:
- Reset values: hold i_reset=1 for 2 cycles, then release -> o_valid=0, o_ready=1, o_mask=0, o_vector=0.
- Auto-commit (AUTO_COMMIT=1): write idx0=0x00010000, idx1=0x00020000, idx2=0x00030000, idx3=0x00040000 on consecutive cycles with i_ready=1 -> o_valid=1 one cycle after the 4th write; x=0x00010000, w=0x00040000, o_mask=4'b1111; returns to COLLECT the next cycle.
- Partial plus commit: write idx2=0xFFFF0000 with i_commit=1 -> o_vector has z=0xFFFF0000 and x=y=w=0, o_mask=4'b0100.
- Overwrite: write idx1=5, then idx1=7, then idx3=9 with commit -> y=7, w=9, o_mask=4'b1010.
- Back-pressure: complete a vector with i_ready=0 for 5 cycles while i_valid=1 with new data -> o_vector stable, o_ready=0, no write absorbed. Then set i_ready=1 -> a single handshake, and the staging register is clear afterwards.
- Reset mid-operation: write lanes 0 and 1, then assert i_reset for 1 cycle -> o_mask=0. Then write idx3 with commit -> o_mask=4'b1000 and x=y=0.
